// File: rtl/mem_port_arbiter.sv
// Shared-memory port arbiter for a pipelined core: one memory port serves
// both instruction fetches (IF stage) and data accesses (EX/MEM stage).
// Data wins when both requests arrive together from IDLE. A fetch queued
// behind a data access always goes next, so fetches cannot be starved.
// Optional feature macro: ARB_TIMEOUT_EN adds an access-timeout watchdog
// with a sticky error flag.
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic ifReq,
  input  logic exmemMemRead,
  input  logic exmemMemWrite,
  input  logic memReady,
  output logic memStart,
  output logic iord,
  output logic memWrite,
  output logic PCWrite,
  output logic IFIDWrite,
  output logic pipeStall,
  output logic timeoutErr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    INST = 2'd2
  } state_t;

  state_t state;
  state_t next_state;
  logic   start_next;
  logic   iord_next;
  logic   write_next;
  logic   data_req;
  logic   timeout_hit;

  assign data_req = exmemMemRead | exmemMemWrite;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] wait_cnt;
  logic       err;

  // The wait that would bring the counter to LIMIT aborts the access.
  assign timeout_hit = (state != IDLE) && !memReady && ((wait_cnt + 8'd1) == LIMIT);

  // Watchdog: restart on every launch, count stalled access cycles, latch error.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 8'd0;
      err      <= 1'b0;
    end else begin
      if (start_next) begin
        wait_cnt <= 8'd0;
      end else if ((state != IDLE) && !memReady) begin
        wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= wait_cnt;
      end
      if (timeout_hit) begin
        err <= 1'b1;
      end else begin
        err <= err;
      end
    end
  end

  assign timeoutErr = err;
`else
  assign timeout_hit = 1'b0;
  assign timeoutErr  = 1'b0;
`endif

  // Next state and the values the registered port controls take next cycle.
  always_comb begin
    next_state = state;
    start_next = 1'b0;
    iord_next  = iord;
    write_next = memWrite;
    case (state)
      IDLE: begin
        if (data_req) begin
          next_state = DATA;
          start_next = 1'b1;
          iord_next  = 1'b1;
          write_next = exmemMemWrite;
        end else if (ifReq) begin
          next_state = INST;
          start_next = 1'b1;
          iord_next  = 1'b0;
          write_next = 1'b0;
        end else begin
          next_state = IDLE;
          iord_next  = 1'b0;
          write_next = 1'b0;
        end
      end
      DATA: begin
        if (timeout_hit) begin
          next_state = IDLE;
          iord_next  = 1'b0;
          write_next = 1'b0;
        end else if (!memReady) begin
          next_state = DATA;
        end else if (ifReq) begin
          // Pending fetch goes ahead of any newly arrived data request.
          next_state = INST;
          start_next = 1'b1;
          iord_next  = 1'b0;
          write_next = 1'b0;
        end else begin
          next_state = IDLE;
          iord_next  = 1'b0;
          write_next = 1'b0;
        end
      end
      INST: begin
        if (timeout_hit) begin
          next_state = IDLE;
          iord_next  = 1'b0;
          write_next = 1'b0;
        end else if (!memReady) begin
          next_state = INST;
        end else if (data_req) begin
          next_state = DATA;
          start_next = 1'b1;
          iord_next  = 1'b1;
          write_next = exmemMemWrite;
        end else if (ifReq) begin
          next_state = INST;
          start_next = 1'b1;
          iord_next  = 1'b0;
          write_next = 1'b0;
        end else begin
          next_state = IDLE;
          iord_next  = 1'b0;
          write_next = 1'b0;
        end
      end
      default: begin
        next_state = IDLE;
        iord_next  = 1'b0;
        write_next = 1'b0;
      end
    endcase
  end

  // State and registered port controls; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      memStart <= 1'b0;
      iord     <= 1'b0;
      memWrite <= 1'b0;
    end else begin
      state    <= next_state;
      memStart <= start_next;
      iord     <= iord_next;
      memWrite <= write_next;
    end
  end

  assign PCWrite   = (state == INST) && memReady;
  assign IFIDWrite = (state == INST) && memReady;
  assign pipeStall = ((state == DATA) && !memReady) || ((state == IDLE) && data_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Each step drives inputs just after
// a rising edge and queues the outputs expected in that cycle; a monitor
// pops and compares them on the falling edge.
// Expected vector bit order: {memStart, iord, memWrite, PCWrite, IFIDWrite, pipeStall, timeoutErr}
module tb_mem_port_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 64;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ifReq = 1'b0;
  logic exmemMemRead = 1'b0;
  logic exmemMemWrite = 1'b0;
  logic memReady = 1'b0;
  logic memStart, iord, memWrite, PCWrite, IFIDWrite, pipeStall, timeoutErr;

  typedef struct {
    string      tag;
    logic [6:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   passed = 0;

  mem_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .ifReq(ifReq), .exmemMemRead(exmemMemRead),
    .exmemMemWrite(exmemMemWrite), .memReady(memReady), .memStart(memStart),
    .iord(iord), .memWrite(memWrite), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .pipeStall(pipeStall), .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  // Compare this cycle's outputs against the queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [6:0] obs;
      e   = sb.pop_front();
      obs = {memStart, iord, memWrite, PCWrite, IFIDWrite, pipeStall, timeoutErr};
      total++;
      assert (obs === e.exp) passed++;
      else $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
    end
  end

  task automatic cyc(input string tag, input logic rst, input logic ifr,
                     input logic rd, input logic wr, input logic rdy,
                     input logic [6:0] exp, input logic chk);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; ifReq = ifr; exmemMemRead = rd; exmemMemWrite = wr; memReady = rdy;
    if (chk) begin
      e.tag = tag;
      e.exp = exp;
      sb.push_back(e);
    end
  endtask

  task automatic chk_now(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    #2;
    obs = {memStart, iord, memWrite, PCWrite, IFIDWrite, pipeStall, timeoutErr};
    total++;
    if (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    // reset
    cyc("rst_pre",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 1'b0);
    cyc("rst",       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 1'b1);
    chk_now("rst_state", 7'b0000000);
    // single fetch, memReady one cycle after memStart
    cyc("f_idle",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000, 1'b1);
    cyc("f_start",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1000000, 1'b1);
    cyc("f_done",    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0001100, 1'b1);
    cyc("f_after",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 1'b1);
    // load and fetch together: data first, fetch with no bubble
    cyc("lf_idle",   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'b0000010, 1'b1);
    cyc("lf_data",   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 7'b1100000, 1'b1);
    cyc("lf_inst",   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b1001100, 1'b1);
    cyc("lf_after",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 1'b1);
    // store with memReady delayed three cycles
    cyc("st_idle",   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b0000010, 1'b1);
    cyc("st_w1",     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b1110010, 1'b1);
    cyc("st_w2",     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b0110010, 1'b1);
    cyc("st_w3",     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b0110010, 1'b1);
    cyc("st_done",   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'b0110000, 1'b1);
    cyc("st_after",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 1'b1);
    // fetch wins after data even with a new data request; then INST -> DATA
    cyc("ns_idle",   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'b0000010, 1'b1);
    cyc("ns_data",   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 7'b1100000, 1'b1);
    cyc("ns_inst",   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'b1000000, 1'b1);
    cyc("ns_idone",  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 7'b0001100, 1'b1);
    cyc("ns_data2",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b1100000, 1'b1);
    cyc("ns_after",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 1'b1);
    // back-to-back fetches
    cyc("ff_idle",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000, 1'b1);
    cyc("ff_i1",     1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7'b1001100, 1'b1);
    cyc("ff_i2",     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b1001100, 1'b1);
    cyc("ff_after",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 1'b1);
    // reset mid-DATA, then memReady in IDLE is ignored
    cyc("rd_idle",   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0000010, 1'b1);
    cyc("rd_start",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b1100010, 1'b1);
    cyc("rd_rst",    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0100010, 1'b1);
    cyc("rd_ign1",   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000000, 1'b1);
    cyc("rd_ign2",   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000000, 1'b1);
    cyc("rd_ign3",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 1'b1);
    // long wait on a load
    cyc("to_idle",   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0000010, 1'b1);
    cyc("to_w1",     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b1100010, 1'b1);
    cyc("to_w2",     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0100010, 1'b1);
    cyc("to_w3",     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0100010, 1'b1);
    cyc("to_w4",     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0100010, 1'b1);
`ifdef ARB_TIMEOUT_EN
    cyc("to_err",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000001, 1'b1);
    chk_now("to_expired", 7'b0000001);
    cyc("to_sticky", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000001, 1'b1);
    cyc("to_rst",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000001, 1'b1);
    cyc("to_clear",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 1'b1);
`else
    cyc("to_w5",     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0100010, 1'b1);
    cyc("to_done",   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0100000, 1'b1);
    chk_now("to_noexpire", 7'b0100000);
    cyc("to_after",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 1'b1);
`endif
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
